// File: rtl/uhf_tx_pkg.sv
// Shared types for the UHF TX frame scheduler:
// FSM state encoding, default widths, descriptor bundle.
package uhf_tx_pkg;

  localparam int PTR_W_DEF = 13;
  localparam int GAP_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_WAIT_DONE,
    S_GAP
  } uhf_tx_sched_state_t;

  typedef struct packed {
    logic [PTR_W_DEF-1:0] start_ptr;
    logic [PTR_W_DEF-1:0] end_ptr;
  } uhf_tx_desc_t;

endpackage

// File: rtl/uhf_tx_desc_fifo.sv
// Descriptor FIFO: DEPTH entries of DW bits, push/pop/flush.
// Ports: clk, rst (async high), push, pop, flush,
//   wr_data, rd_data (head, combinational), count, full, empty.
// Flush has priority over push and pop in the same cycle.
module uhf_tx_desc_fifo
  import uhf_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 2 * PTR_W_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uhf_tx_frame_scheduler.sv
// Back-to-back UHF TX frame scheduler: queues start/end pointer
// descriptors, arms the TX engine, waits for done, enforces a gap.
// Ports: i_PCLK, i_Reset (async high); i_enable, i_flush;
//   descriptor push i_desc_valid/o_desc_ready/i_desc_start/end;
//   i_gap_cycles, i_wd_cycles; engine o_EN_TX, o_start_ptr,
//   o_end_ptr, i_transmit_done; status o_busy, o_fifo_count,
//   o_frames_sent, o_err_desc, o_err_timeout.
// Build option: UHF_TX_SCHED_WATCHDOG_EN adds the WAIT_DONE watchdog.
module uhf_tx_frame_scheduler
  import uhf_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = PTR_W_DEF,
  parameter int GAP_W = GAP_W_DEF,
  parameter int WD_W  = 24
) (
  input  logic                         i_PCLK,
  input  logic                         i_Reset,
  input  logic                         i_enable,
  input  logic                         i_flush,
  input  logic                         i_desc_valid,
  output logic                         o_desc_ready,
  input  logic [PTR_W-1:0]             i_desc_start,
  input  logic [PTR_W-1:0]             i_desc_end,
  input  logic [GAP_W-1:0]             i_gap_cycles,
  input  logic [WD_W-1:0]              i_wd_cycles,
  output logic                         o_EN_TX,
  output logic [PTR_W-1:0]             o_start_ptr,
  output logic [PTR_W-1:0]             o_end_ptr,
  input  logic                         i_transmit_done,
  output logic                         o_busy,
  output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count,
  output logic [7:0]                   o_frames_sent,
  output logic                         o_err_desc,
  output logic                         o_err_timeout
);

  localparam int CW = $clog2(DEPTH + 1);

  uhf_tx_sched_state_t state, state_n;

  logic [2*PTR_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               desc_bad;
  logic               fifo_push;
  logic               pop;
  logic               frame_done;
  logic               wd_hit;
  logic               can_load;
  logic [1:0]         sync_q;
  logic               done_d;
  logic               done_rise;
  logic [GAP_W-1:0]   gap_cnt;
  logic               gap_last;
  logic               en_tx_q;

  assign desc_bad     = (i_desc_end < i_desc_start);
  assign fifo_push    = i_desc_valid && !desc_bad && !i_flush;
  assign o_desc_ready = !fifo_full;

  uhf_tx_desc_fifo #(
    .DEPTH (DEPTH),
    .DW    (2 * PTR_W),
    .CW    (CW)
  ) u_fifo (
    .clk     (i_PCLK),
    .rst     (i_Reset),
    .push    (fifo_push),
    .pop     (pop),
    .flush   (i_flush),
    .wr_data ({i_desc_start, i_desc_end}),
    .rd_data (head),
    .count   (o_fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Done comes from the TXRX clock domain: two-flop sync, then
  // an edge register so only a fresh 0->1 ends a frame.
  always_ff @(posedge i_PCLK or posedge i_Reset) begin
    if (i_Reset) begin
      sync_q <= '0;
      done_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_transmit_done};
      done_d <= sync_q[1];
    end
  end

  assign done_rise = sync_q[1] && !done_d;

  // A flush in the deciding cycle empties the FIFO, so never
  // commit to LOAD on the same edge.
  assign can_load = i_enable && !fifo_empty && !i_flush;
  assign gap_last = (gap_cnt < GAP_W'(2));

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (can_load) state_n = S_LOAD;
      end
      S_LOAD: begin
        pop     = 1'b1;
        state_n = S_ARM;
      end
      S_ARM: begin
        state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_rise) begin
          frame_done = 1'b1;
          state_n    = S_GAP;
        end else if (wd_hit) begin
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_last) state_n = can_load ? S_LOAD : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_PCLK or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= S_IDLE;
      en_tx_q       <= 1'b0;
      o_start_ptr   <= '0;
      o_end_ptr     <= '0;
      o_frames_sent <= '0;
      o_err_desc    <= 1'b0;
    end else begin
      state      <= state_n;
      // Enable is asserted out of ARM and held for WAIT_DONE only.
      en_tx_q    <= (state_n == S_WAIT_DONE);
      o_err_desc <= i_desc_valid && o_desc_ready && desc_bad;
      if (pop) begin
        o_start_ptr <= head[2*PTR_W-1:PTR_W];
        o_end_ptr   <= head[PTR_W-1:0];
      end
      if (frame_done) o_frames_sent <= o_frames_sent + 8'd1;
    end
  end

  // Reloads every cycle outside GAP, so the value latched is the
  // one present on the GAP entry edge.
  always_ff @(posedge i_PCLK or posedge i_Reset) begin
    if (i_Reset) begin
      gap_cnt <= '0;
    end else if (state != S_GAP) begin
      gap_cnt <= i_gap_cycles;
    end else if (!gap_last) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

`ifdef UHF_TX_SCHED_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt;
  logic            err_to_q;

  assign wd_hit = (state == S_WAIT_DONE) &&
                  (i_wd_cycles != '0) &&
                  (wd_cnt == i_wd_cycles - 1'b1);

  always_ff @(posedge i_PCLK or posedge i_Reset) begin
    if (i_Reset) begin
      wd_cnt   <= '0;
      err_to_q <= 1'b0;
    end else begin
      if (state != S_WAIT_DONE) wd_cnt <= '0;
      else                      wd_cnt <= wd_cnt + 1'b1;
      if (i_flush)                    err_to_q <= 1'b0;
      else if (wd_hit && !done_rise)  err_to_q <= 1'b1;
    end
  end

  assign o_err_timeout = err_to_q;
`else
  logic unused_wd;
  assign unused_wd     = ^i_wd_cycles;
  assign wd_hit        = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  assign o_EN_TX = en_tx_q;
  assign o_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_uhf_tx_frame_scheduler.sv
// Directed bench for uhf_tx_frame_scheduler: descriptor table,
// frame sequencing, gap timing, done edge rules, flush, watchdog.
module tb_uhf_tx_frame_scheduler;
  import uhf_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic        vld;
  logic        rdy;
  logic [12:0] ds;
  logic [12:0] de;
  logic [15:0] gap;
  logic [23:0] wd;
  logic        en_tx;
  logic [12:0] sp;
  logic [12:0] ep;
  logic        done;
  logic        busy;
  logic [2:0]  cnt;
  logic [7:0]  frames;
  logic        err_d;
  logic        err_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uhf_tx_frame_scheduler dut (
    .i_PCLK          (clk),
    .i_Reset         (rst),
    .i_enable        (en),
    .i_flush         (flush),
    .i_desc_valid    (vld),
    .o_desc_ready    (rdy),
    .i_desc_start    (ds),
    .i_desc_end      (de),
    .i_gap_cycles    (gap),
    .i_wd_cycles     (wd),
    .o_EN_TX         (en_tx),
    .o_start_ptr     (sp),
    .o_end_ptr       (ep),
    .i_transmit_done (done),
    .o_busy          (busy),
    .o_fifo_count    (cnt),
    .o_frames_sent   (frames),
    .o_err_desc      (err_d),
    .o_err_timeout   (err_t)
  );

  typedef struct {
    logic [12:0] s;
    logic [12:0] e;
    logic        acc;
    logic        err;
    logic [2:0]  cnt;
    logic        rdy;
  } vec_t;

  vec_t         vecs [7];
  uhf_tx_desc_t expq [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [12:0] s, input logic [12:0] e);
    vld = 1'b1;
    ds  = s;
    de  = e;
    tick();
    vld = 1'b0;
  endtask

  task automatic wait_en(input logic v, input int lim, output int n);
    n = 0;
    while (en_tx !== v && n < lim) begin
      tick();
      n++;
    end
    chk("wait_en", 32'(en_tx), 32'(v));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle", 32'(busy), 32'd0);
  endtask

  // Done held 2 edges; EN_TX must still be high after 2 and low after 3.
  task automatic done_pulse();
    done = 1'b1;
    tick();
    tick();
    chk("en_before_done_lat", 32'(en_tx), 32'd1);
    done = 1'b0;
    tick();
    chk("done_to_en_low", 32'(en_tx), 32'd0);
  endtask

  task automatic low_time(output int low);
    low = 1;
    for (int k = 0; k < 40 && en_tx == 1'b0; k++) begin
      tick();
      if (en_tx == 1'b0) low++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int low;

    vecs[0] = '{13'h100,  13'h0FF,  1'b0, 1'b1, 3'd0, 1'b1};
    vecs[1] = '{13'h100,  13'h100,  1'b1, 1'b0, 3'd1, 1'b1};
    vecs[2] = '{13'h000,  13'h01F,  1'b1, 1'b0, 3'd2, 1'b1};
    vecs[3] = '{13'h020,  13'h1FFF, 1'b1, 1'b0, 3'd3, 1'b1};
    vecs[4] = '{13'h1FFE, 13'h1FFF, 1'b1, 1'b0, 3'd4, 1'b0};
    vecs[5] = '{13'h005,  13'h006,  1'b0, 1'b0, 3'd4, 1'b0};
    vecs[6] = '{13'h009,  13'h001,  1'b0, 1'b0, 3'd4, 1'b0};

    rst = 1'b1; en = 1'b0; flush = 1'b0; vld = 1'b0;
    ds = '0; de = '0; gap = 16'd10; wd = '0; done = 1'b0;
    repeat (3) tick();
    chk("rst_en_tx",  32'(en_tx),  32'd0);
    chk("rst_ready",  32'(rdy),    32'd1);
    chk("rst_count",  32'(cnt),    32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_frames", 32'(frames), 32'd0);
    chk("rst_err",    32'(err_d),  32'd0);
    chk("rst_err_to", 32'(err_t),  32'd0);
    chk("rst_sp",     32'(sp),     32'd0);
    rst = 1'b0;
    tick();

    // Single frame latency.
    en = 1'b1;
    push(13'h000, 13'h01F);
    chk("t1_count", 32'(cnt), 32'd1);
    tick();
    chk("t1_en_p1", 32'(en_tx), 32'd0);
    tick();
    chk("t1_en_p2", 32'(en_tx), 32'd0);
    tick();
    chk("t1_en_p3", 32'(en_tx), 32'd1);
    chk("t1_sp", 32'(sp), 32'h000);
    chk("t1_ep", 32'(ep), 32'h01F);
    chk("t1_count0", 32'(cnt), 32'd0);
    tick();
    done_pulse();
    chk("t1_frames", 32'(frames), 32'd1);
    wait_idle();

    // Descriptor table while disabled.
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].s, vecs[i].e);
      chk($sformatf("v%0d_err", i),   32'(err_d), 32'(vecs[i].err));
      chk($sformatf("v%0d_count", i), 32'(cnt),   32'(vecs[i].cnt));
      chk($sformatf("v%0d_ready", i), 32'(rdy),   32'(vecs[i].rdy));
      tick();
      chk($sformatf("v%0d_err_1cyc", i), 32'(err_d), 32'd0);
      if (vecs[i].acc) expq.push_back('{vecs[i].s, vecs[i].e});
    end

    // Four frames in order, gap 10 -> 12 low cycles between.
    gap = 16'd10;
    en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_en(1'b1, 20, n);
      chk($sformatf("f%0d_sp", i), 32'(sp), 32'(expq[i].start_ptr));
      chk($sformatf("f%0d_ep", i), 32'(ep), 32'(expq[i].end_ptr));
      tick();
      tick();
      done_pulse();
      if (i < 3) begin
        low_time(low);
        chk($sformatf("f%0d_low", i), 32'(low), 32'd12);
      end
    end
    chk("f_frames", 32'(frames), 32'd5);
    wait_idle();
    chk("f_count", 32'(cnt), 32'd0);

    // Done already high before ARM is ignored.
    done = 1'b1;
    repeat (4) tick();
    push(13'h200, 13'h2FF);
    wait_en(1'b1, 10, n);
    repeat (10) tick();
    chk("hold_no_done", 32'(en_tx), 32'd1);
    done = 1'b0;
    repeat (4) tick();
    chk("hold_low_no_done", 32'(en_tx), 32'd1);
    done_pulse();
    chk("hold_frames", 32'(frames), 32'd6);
    wait_idle();

    // Zero gap, then enable dropped mid-frame.
    en = 1'b0;
    push(13'h010, 13'h011);
    push(13'h012, 13'h013);
    push(13'h014, 13'h015);
    gap = 16'd0;
    en  = 1'b1;
    wait_en(1'b1, 10, n);
    chk("g0_sp0", 32'(sp), 32'h010);
    done_pulse();
    low_time(low);
    chk("g0_low", 32'(low), 32'd3);
    chk("g0_sp1", 32'(sp), 32'h012);
    en = 1'b0;
    tick();
    done_pulse();
    wait_idle();
    chk("dis_count", 32'(cnt), 32'd1);
    chk("dis_frames", 32'(frames), 32'd8);
    chk("dis_en", 32'(en_tx), 32'd0);

    // Flush with 3 queued during a frame; push in flush cycle lost.
    gap = 16'd10;
    en  = 1'b1;
    wait_en(1'b1, 10, n);
    chk("fl_sp", 32'(sp), 32'h014);
    push(13'h020, 13'h021);
    push(13'h022, 13'h023);
    push(13'h024, 13'h025);
    chk("fl_count3", 32'(cnt), 32'd3);
    flush = 1'b1;
    push(13'h030, 13'h031);
    flush = 1'b0;
    chk("fl_count0", 32'(cnt), 32'd0);
    chk("fl_en_kept", 32'(en_tx), 32'd1);
    tick();
    chk("fl_count0b", 32'(cnt), 32'd0);
    done_pulse();
    wait_idle();
    chk("fl_frames", 32'(frames), 32'd9);
    chk("fl_count_end", 32'(cnt), 32'd0);
    chk("fl_en_end", 32'(en_tx), 32'd0);

`ifdef UHF_TX_SCHED_WATCHDOG_EN
    wd = 24'd1000;
    push(13'h040, 13'h041);
    push(13'h042, 13'h043);
    wait_en(1'b1, 10, n);
    wait_en(1'b0, 1100, n);
    chk("wd_cycles", 32'(n), 32'd1000);
    chk("wd_err", 32'(err_t), 32'd1);
    chk("wd_frames", 32'(frames), 32'd9);
    wait_en(1'b1, 30, n);
    chk("wd_next_sp", 32'(sp), 32'h042);
    done_pulse();
    chk("wd_frames2", 32'(frames), 32'd10);
    wait_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("wd_err_clr", 32'(err_t), 32'd0);
    wd = '0;
`else
    chk("no_wd_err", 32'(err_t), 32'd0);
`endif

    // Reset mid-frame drops EN_TX without a clock edge.
    push(13'h050, 13'h051);
    wait_en(1'b1, 10, n);
    rst = 1'b1;
    #2;
    chk("arst_en", 32'(en_tx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frames", 32'(frames), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
